// File: rtl/motors_pkg.sv
// Shared definitions for the motor command controller.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
//
// Holds the controller state enum, the default parameter values used by
// motors_cmd_ctrl, and the helper that locates a per-motor slice in a
// packed per-motor bus.
package motors_pkg;

  localparam int DEF_NUM_MOTORS  = 4;
  localparam int DEF_THR_W       = 11;
  localparam int DEF_THR_MAX     = 2047;
  localparam int DEF_WDOG_CYCLES = 10000000;
  localparam int DEF_SLEW_STEP   = 64;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FAILSAFE = 2'd2
  } motors_state_e;

  // LSB position of element idx in a packed bus of width-bit elements.
  // Called with elaboration-time constants, so it folds away entirely.
  function automatic int unsigned thr_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/motors_wdog.sv
// Command watchdog: flags when the armed controller has gone too long without a commit.
// Latency: expired is combinational from the count; count updates one cycle after clear/enable.
// Backpressure: none; clear always wins over counting.
//
// Ports:
//   aclk, aresetn : clock, async active-low reset
//   clear         : restart the count (a commit was seen)
//   enable        : count only while high (controller armed)
//   expired       : high while enabled and the count sits at CYCLES-1
module motors_wdog
  import motors_pkg::*;
#(
  parameter int CYCLES = DEF_WDOG_CYCLES
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == CW'(CYCLES - 1));

  // The count parks at CYCLES-1 once expired; the controller leaves ARMED
  // on that edge, and every way back into ARMED passes through a clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/motors_cmd_ctrl.sv
// Motor command controller: turns committed register values into per-motor arm/telemetry/throttle.
// Latency: 1 cycle from reg_commit to updated outputs plus cmd_valid pulse.
// Backpressure: none; every honoured commit or failsafe entry produces exactly one cmd_valid.
//
// Ports:
//   aclk, aresetn  : clock, async active-low reset
//   reg_arm/reg_tlm: 32-bit request words, bit i for motor i (bits >= NUM_MOTORS ignored)
//   reg_thr        : NUM_MOTORS 32-bit throttle words, clamped to THR_MAX
//   reg_commit     : one-cycle strobe that samples the request registers
//   arm/tlm/throttle/cmd_valid/failsafe : registered command outputs
// Build option: define MOTORS_SLEW_LIMIT_EN to rate-limit throttle increases
// to SLEW_STEP per commit (decreases still apply immediately).
module motors_cmd_ctrl
  import motors_pkg::*;
#(
  parameter int NUM_MOTORS  = DEF_NUM_MOTORS,
  parameter int THR_W       = DEF_THR_W,
  parameter int THR_MAX     = DEF_THR_MAX,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES,
  parameter int SLEW_STEP   = DEF_SLEW_STEP
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [31:0]                 reg_arm,
  input  logic [31:0]                 reg_tlm,
  input  logic [NUM_MOTORS*32-1:0]    reg_thr,
  input  logic                        reg_commit,
  output logic [NUM_MOTORS-1:0]       arm,
  output logic [NUM_MOTORS-1:0]       tlm,
  output logic [NUM_MOTORS*THR_W-1:0] throttle,
  output logic                        cmd_valid,
  output logic                        failsafe
);

  motors_state_e              state;
  logic [NUM_MOTORS-1:0]       arm_req;
  logic [NUM_MOTORS-1:0]       tlm_req;
  logic                        arm_any;
  logic [NUM_MOTORS*THR_W-1:0] thr_upd;
  logic                        wd_expired;

  assign arm_req = reg_arm[NUM_MOTORS-1:0];
  assign tlm_req = reg_tlm[NUM_MOTORS-1:0];
  assign arm_any = |arm_req;

  // Request bits above the motor count carry no meaning here.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{reg_arm[31:NUM_MOTORS], reg_tlm[31:NUM_MOTORS]};

`ifndef MOTORS_SLEW_LIMIT_EN
  localparam int unused_slew_step = SLEW_STEP;
`endif

  for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_motor
    logic [31:0]      word;
    logic [THR_W-1:0] tgt;
    logic [THR_W-1:0] thr_next;

    assign word = reg_thr[thr_lsb(i, 32) +: 32];
    // Compare on the full 32-bit word so large values clamp instead of wrapping.
    assign tgt  = (word > 32'(THR_MAX)) ? THR_W'(THR_MAX) : word[THR_W-1:0];

`ifdef MOTORS_SLEW_LIMIT_EN
    logic [THR_W-1:0] cur;
    logic [32:0]      ceil_v;
    assign cur    = throttle[thr_lsb(i, THR_W) +: THR_W];
    // Wide sum so cur+SLEW_STEP cannot wrap; the truncating branch is only
    // taken when the ceiling is below tgt, hence within THR_W bits.
    assign ceil_v = 33'(cur) + 33'(SLEW_STEP);
    assign thr_next = (33'(tgt) <= ceil_v) ? tgt : cur + THR_W'(SLEW_STEP);
`else
    assign thr_next = tgt;
`endif

    // A motor whose arm bit is clear always gets zero throttle.
    assign thr_upd[thr_lsb(i, THR_W) +: THR_W] = arm_req[i] ? thr_next : '0;
  end

  motors_wdog #(
    .CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (reg_commit),
    .enable  (state == ST_ARMED),
    .expired (wd_expired)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_DISARMED;
      arm       <= '0;
      tlm       <= '0;
      throttle  <= '0;
      cmd_valid <= 1'b0;
      failsafe  <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      case (state)
        ST_DISARMED, ST_ARMED: begin
          // A commit takes priority over a watchdog expiry in the same cycle.
          if (reg_commit) begin
            cmd_valid <= 1'b1;
            tlm       <= tlm_req;
            if (arm_any) begin
              state    <= ST_ARMED;
              arm      <= arm_req;
              throttle <= thr_upd;
            end else begin
              state    <= ST_DISARMED;
              arm      <= '0;
              throttle <= '0;
            end
          end else if (wd_expired) begin
            state     <= ST_FAILSAFE;
            arm       <= '0;
            tlm       <= '0;
            throttle  <= '0;
            failsafe  <= 1'b1;
            cmd_valid <= 1'b1;
          end
        end
        ST_FAILSAFE: begin
          // Only an explicit all-disarm commit leaves failsafe; arm attempts are dropped.
          if (reg_commit && !arm_any) begin
            state     <= ST_DISARMED;
            failsafe  <= 1'b0;
            cmd_valid <= 1'b1;
            tlm       <= tlm_req;
          end
        end
        default: state <= ST_DISARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_motors_cmd_ctrl.sv
// Bench for motors_cmd_ctrl: directed scenarios plus randomized commits,
// compared every cycle against a rule-level model of the controller.
// Runs with WDOG_CYCLES=16; also covers the MOTORS_SLEW_LIMIT_EN build.
module tb_motors_cmd_ctrl;

  localparam int NM   = 4;
  localparam int TW   = 11;
  localparam int TMAX = 2047;
  localparam int WD   = 16;
  localparam int STEP = 64;

  logic              aclk       = 1'b0;
  logic              aresetn    = 1'b1;
  logic [31:0]       reg_arm    = '0;
  logic [31:0]       reg_tlm    = '0;
  logic [NM*32-1:0]  reg_thr    = '0;
  logic              reg_commit = 1'b0;
  logic [NM-1:0]     arm;
  logic [NM-1:0]     tlm;
  logic [NM*TW-1:0]  throttle;
  logic              cmd_valid;
  logic              failsafe;

  int checks = 0;
  int errors = 0;

  motors_cmd_ctrl #(
    .NUM_MOTORS  (NM),
    .THR_W       (TW),
    .THR_MAX     (TMAX),
    .WDOG_CYCLES (WD),
    .SLEW_STEP   (STEP)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .reg_arm    (reg_arm),
    .reg_tlm    (reg_tlm),
    .reg_thr    (reg_thr),
    .reg_commit (reg_commit),
    .arm        (arm),
    .tlm        (tlm),
    .throttle   (throttle),
    .cmd_valid  (cmd_valid),
    .failsafe   (failsafe)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_DIS, M_ARM, M_FS} mst_e;
  mst_e          ms       = M_DIS;
  int unsigned   cyc      = 0;
  int unsigned   last_cmt = 0;
  logic [NM-1:0] e_arm    = '0;
  logic [NM-1:0] e_tlm    = '0;
  logic          e_cv     = 1'b0;
  logic          e_fs     = 1'b0;
  int unsigned   e_thr [NM] = '{default: 0};

  function automatic logic [NM*TW-1:0] pack_thr();
    logic [NM*TW-1:0] r;
    r = '0;
    for (int i = 0; i < NM; i++) r[i*TW +: TW] = TW'(e_thr[i]);
    return r;
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    logic [31:0] w;
    int unsigned tgt;
    bit          any;
    if (!aresetn) begin
      ms = M_DIS; cyc = 0; last_cmt = 0;
      e_arm = '0; e_tlm = '0; e_cv = 1'b0; e_fs = 1'b0;
      for (int i = 0; i < NM; i++) e_thr[i] = 0;
    end else begin
      cyc++;
      e_cv = 1'b0;
      any  = (reg_arm[NM-1:0] != '0);
      if (reg_commit) begin
        last_cmt = cyc;
        if (!(ms == M_FS && any)) begin
          e_cv  = 1'b1;
          e_fs  = 1'b0;
          e_tlm = reg_tlm[NM-1:0];
          e_arm = any ? reg_arm[NM-1:0] : '0;
          ms    = any ? M_ARM : M_DIS;
          for (int i = 0; i < NM; i++) begin
            w   = reg_thr[i*32 +: 32];
            tgt = (w > TMAX) ? TMAX : w;
            if (!any || !reg_arm[i]) e_thr[i] = 0;
`ifdef MOTORS_SLEW_LIMIT_EN
            else e_thr[i] = (tgt < e_thr[i] + STEP) ? tgt : e_thr[i] + STEP;
`else
            else e_thr[i] = tgt;
`endif
          end
        end
      end else if (ms == M_ARM && (cyc - last_cmt) == WD) begin
        ms = M_FS; e_fs = 1'b1; e_cv = 1'b1;
        e_arm = '0; e_tlm = '0;
        for (int i = 0; i < NM; i++) e_thr[i] = 0;
      end
    end
  end

  // Single compare process: outputs against the model on every cycle out of reset.
  always @(negedge aclk) begin
    if (aresetn) begin
      chk("cyc_arm",       64'(arm),       64'(e_arm));
      chk("cyc_tlm",       64'(tlm),       64'(e_tlm));
      chk("cyc_throttle",  64'(throttle),  64'(pack_thr()));
      chk("cyc_cmd_valid", 64'(cmd_valid), 64'(e_cv));
      chk("cyc_failsafe",  64'(failsafe),  64'(e_fs));
    end
  end

  // ---------------- stimulus ----------------
  task automatic commit(input logic [31:0] a, input logic [31:0] t,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
    @(negedge aclk);
    reg_arm = a; reg_tlm = t; reg_thr = {w3, w2, w1, w0}; reg_commit = 1'b1;
    @(negedge aclk);
    reg_commit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 2047));
      1:       return 32'($urandom_range(2040, 2055));
      2:       return $urandom;
      default: return 32'd0;
    endcase
  endfunction

`ifdef MOTORS_SLEW_LIMIT_EN
  int unsigned slew_exp [5] = '{64, 128, 192, 256, 300};
`endif

  initial begin
    int          gap;
    logic [31:0] a;
    logic [31:0] t;

    #1 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arm",       64'(arm),       64'd0);
    chk("rst_tlm",       64'(tlm),       64'd0);
    chk("rst_throttle",  64'(throttle),  64'd0);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_failsafe",  64'(failsafe),  64'd0);
    @(negedge aclk);
    #2 aresetn = 1'b1;
    idle(3);
    chk("idle_arm",       64'(arm),       64'd0);
    chk("idle_cmd_valid", 64'(cmd_valid), 64'd0);

    // Clamp and arm-all commit.
    commit(32'hF, 32'h3, 32'd100, 32'd200, 32'd3000, 32'h10000);
`ifdef MOTORS_SLEW_LIMIT_EN
    chk("clamp_thr", 64'(throttle), 64'({11'd64, 11'd64, 11'd64, 11'd64}));
`else
    chk("clamp_thr", 64'(throttle), 64'({11'd2047, 11'd2047, 11'd200, 11'd100}));
`endif
    chk("clamp_arm", 64'(arm),       64'hF);
    chk("clamp_tlm", 64'(tlm),       64'h3);
    chk("clamp_cv",  64'(cmd_valid), 64'd1);
    idle(1);
    chk("clamp_cv_once", 64'(cmd_valid), 64'd0);

    // Partial arm zeroes unarmed motors.
    commit(32'h5, 32'h0, 32'd500, 32'd500, 32'd500, 32'd500);
`ifdef MOTORS_SLEW_LIMIT_EN
    chk("partial_thr", 64'(throttle), 64'({11'd0, 11'd128, 11'd0, 11'd128}));
`else
    chk("partial_thr", 64'(throttle), 64'({11'd0, 11'd500, 11'd0, 11'd500}));
`endif
    chk("partial_arm", 64'(arm), 64'h5);

    // Watchdog expiry after WD idle cycles.
    idle(WD - 1);
    chk("wd_not_yet", 64'(failsafe), 64'd0);
    idle(1);
    chk("wd_fs",  64'(failsafe),  64'd1);
    chk("wd_arm", 64'(arm),       64'd0);
    chk("wd_thr", 64'(throttle),  64'd0);
    chk("wd_cv",  64'(cmd_valid), 64'd1);
    idle(1);
    chk("wd_cv_once", 64'(cmd_valid), 64'd0);

    commit(32'hF, 32'hF, 32'd1000, 32'd1000, 32'd1000, 32'd1000);
    chk("fs_ignore_fs",  64'(failsafe),  64'd1);
    chk("fs_ignore_arm", 64'(arm),       64'd0);
    chk("fs_ignore_cv",  64'(cmd_valid), 64'd0);
    commit(32'h0, 32'h2, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("fs_exit_fs",  64'(failsafe),  64'd0);
    chk("fs_exit_cv",  64'(cmd_valid), 64'd1);
    chk("fs_exit_tlm", 64'(tlm),       64'h2);

    // Commit landing exactly on the expiry cycle.
    commit(32'hF, 32'h0, 32'd300, 32'd300, 32'd300, 32'd300);
    idle(WD - 2);
    commit(32'hF, 32'h0, 32'd400, 32'd400, 32'd400, 32'd400);
    chk("race_fs",  64'(failsafe),  64'd0);
    chk("race_arm", 64'(arm),       64'hF);
    chk("race_cv",  64'(cmd_valid), 64'd1);
    idle(WD - 1);
    chk("race_restart_early", 64'(failsafe), 64'd0);
    idle(1);
    chk("race_restart_fs", 64'(failsafe), 64'd1);
    commit(32'h0, 32'h0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Arm bits above the motor count do not arm anything.
    commit(32'hFFF0, 32'hFFF0, 32'd700, 32'd700, 32'd700, 32'd700);
    chk("hi_arm", 64'(arm),       64'd0);
    chk("hi_tlm", 64'(tlm),       64'd0);
    chk("hi_thr", 64'(throttle),  64'd0);
    chk("hi_cv",  64'(cmd_valid), 64'd1);
    idle(WD + 4);
    chk("hi_no_wd", 64'(failsafe), 64'd0);

    // Asynchronous reset mid-operation, then a commit right at release.
    commit(32'hF, 32'h1, 32'd800, 32'd800, 32'd800, 32'd800);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_arm", 64'(arm),      64'd0);
    chk("arst_thr", 64'(throttle), 64'd0);
    chk("arst_tlm", 64'(tlm),      64'd0);
    @(negedge aclk);
    #2;
    reg_arm = 32'hA; reg_tlm = 32'h0;
    reg_thr = {32'd900, 32'd900, 32'd900, 32'd900};
    reg_commit = 1'b1;
    aresetn = 1'b1;
    @(negedge aclk);
    reg_commit = 1'b0;
    chk("first_cmt_arm", 64'(arm),       64'hA);
    chk("first_cmt_cv",  64'(cmd_valid), 64'd1);
`ifndef MOTORS_SLEW_LIMIT_EN
    chk("first_cmt_thr", 64'(throttle), 64'({11'd900, 11'd0, 11'd900, 11'd0}));
`endif

`ifdef MOTORS_SLEW_LIMIT_EN
    commit(32'h0, 32'h0, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      commit(32'hF, 32'h0, 32'd300, 32'd300, 32'd300, 32'd300);
      chk("slew_up", 64'(throttle[0 +: TW]), 64'(slew_exp[k]));
    end
    commit(32'hF, 32'h0, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("slew_down", 64'(throttle[0 +: TW]), 64'd0);
`endif

    // Randomized commits with occasional long gaps to trip the watchdog.
    for (int it = 0; it < 400; it++) begin
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
      idle(gap);
      case ($urandom_range(0, 4))
        0:       a = 32'h0;
        1:       a = $urandom & 32'hFFFF_FFF0;
        default: a = $urandom;
      endcase
      t = $urandom;
      commit(a, t, rand_word(), rand_word(), rand_word(), rand_word());
    end

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motors_cmd_ctrl.md
MOTORS_CMD_CTRL -- requirements
Module: motors_cmd_ctrl

Interface
REQ-001 Parameter NUM_MOTORS, default 4: number of motor channels, range 1..16.
REQ-002 Parameter THR_W, default 11: throttle width in bits.
REQ-003 Parameter THR_MAX, default 2047: clamp ceiling, no greater than 2^THR_W-1.
REQ-004 Parameter WDOG_CYCLES, default 10000000: maximum number of aclk cycles allowed between commits while armed.
REQ-005 Parameter SLEW_STEP, default 64: maximum throttle increase per commit; used only when MOTORS_SLEW_LIMIT_EN is defined.
REQ-006 aclk  in  1  single clock; all logic is rising-edge.
REQ-007 aresetn  in  1  asynchronous active-low reset.
REQ-008 reg_arm  in  32  arm request; bit i arms motor i.
REQ-009 reg_tlm  in  32  telemetry request; bit i requests telemetry for motor i.
REQ-010 reg_thr  in  NUM_MOTORS*32  throttle registers; word i is motor i.
REQ-011 reg_commit  in  1  one-cycle strobe from the register-write decode of the commit register.
REQ-012 arm  out  NUM_MOTORS  per-motor arm.
REQ-013 tlm  out  NUM_MOTORS  per-motor telemetry request.
REQ-014 throttle  out  NUM_MOTORS*THR_W  per-motor throttle, motor i at bits [i*THR_W +: THR_W].
REQ-015 cmd_valid  out  1  one-cycle pulse whenever the outputs take a new value.
REQ-016 failsafe  out  1  high while the block is in the FAILSAFE state.

Function
REQ-017 The block SHALL implement three states: DISARMED, ARMED and FAILSAFE.
REQ-018 On reg_commit the block SHALL sample reg_arm, reg_tlm and reg_thr, and SHALL drive the resulting outputs and the cmd_valid pulse on the next cycle (latency 1).
REQ-019 Outputs SHALL hold their values between commits.
REQ-020 Clamp rule: if reg_thr word i has value > THR_MAX (all 32 bits considered), target i SHALL equal THR_MAX; otherwise target i SHALL equal the word's value.
REQ-021 In DISARMED, a commit with any arm bit in [NUM_MOTORS-1:0] set SHALL enter ARMED; a commit with all arm bits zero SHALL remain in DISARMED, update tlm and force throttle to 0.
REQ-022 In ARMED, a commit with all arm bits zero SHALL enter DISARMED.
REQ-023 In ARMED, for every motor whose arm bit is 0, the block SHALL force that motor's throttle to 0.
REQ-024 Watchdog: the counter SHALL clear on every commit and SHALL count only in ARMED.
REQ-025 When the watchdog count reaches WDOG_CYCLES-1 without a commit, the block SHALL enter FAILSAFE next cycle.
REQ-026 On entering FAILSAFE: arm=0, throttle=0, tlm=0, failsafe=1, with a single cmd_valid pulse.
REQ-027 In FAILSAFE, a commit with any arm bit set SHALL be ignored: no output change and no cmd_valid.
REQ-028 In FAILSAFE, a commit with all arm bits zero SHALL enter DISARMED, clear failsafe and pulse cmd_valid.
REQ-029 If a commit and watchdog expiry occur in the same cycle, the commit SHALL win and no failsafe SHALL occur.
REQ-030 reg_arm and reg_tlm bits at positions >= NUM_MOTORS SHALL be ignored.

Reset
REQ-031 While aresetn is low: state=DISARMED; arm, tlm, throttle, cmd_valid and failsafe all 0; watchdog counter 0; slew registers 0.
REQ-032 If reset is asserted mid-operation, the block SHALL return to the reset values immediately (asynchronously).
REQ-033 A reg_commit strobe present in the first cycle after reset release SHALL be honoured.

Configuration
REQ-034 With MOTORS_SLEW_LIMIT_EN defined, an armed motor's throttle SHALL increase per commit by at most SLEW_STEP (new = min(target, old+SLEW_STEP)), and decreases SHALL apply immediately.
REQ-035 With MOTORS_SLEW_LIMIT_EN undefined, throttle SHALL equal the target directly and the slew logic SHALL be absent.

Structure
REQ-036 Package motors_pkg SHALL hold the state enum typedef, the default constants (NUM_MOTORS, THR_W, THR_MAX, WDOG_CYCLES, SLEW_STEP) and the throttle-slice helper function.
REQ-037 The watchdog SHALL be a sub-module, motors_wdog, with clear, enable and expired ports.

Verification
REQ-038 Reset with reg_commit=0 -> all outputs 0 and state DISARMED.
REQ-039 Commit reg_arm=0xF, reg_thr={100,200,3000,0x10000} -> one cycle later throttle={100,200,2047,2047}, arm=0xF, cmd_valid pulses once.
REQ-040 Bench with WDOG_CYCLES=16: arm, then no commit for 16 cycles -> failsafe=1, arm=0, throttle=0; a later commit with arm=0xF is ignored; a commit with arm=0 -> DISARMED, failsafe=0.
REQ-041 Commit strobed exactly on the watchdog expiry cycle -> no failsafe, counter restarts.
REQ-042 Commit reg_arm=0x5, throttle=500 on all motors -> throttle={500,0,500,0}.
REQ-043 With MOTORS_SLEW_LIMIT_EN defined and armed, commits of target 300 from 0 -> throttle steps 64, 128, 192, 256, 300; a subsequent target of 0 -> 0 immediately.
